// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router control path: state encoding,
// the dropped-address value and the output channel count.
package router_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [STATE_W-1:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [STATE_W-1:0] LOAD_DATA          = 3'd2;
    localparam logic [STATE_W-1:0] LOAD_PARITY        = 3'd3;
    localparam logic [STATE_W-1:0] CHECK_PARITY_ERROR = 3'd4;
    localparam logic [STATE_W-1:0] FIFO_FULL_STATE    = 3'd5;
    localparam logic [STATE_W-1:0] LOAD_AFTER_FULL    = 3'd6;
    localparam logic [STATE_W-1:0] WAIT_TILL_EMPTY    = 3'd7;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    localparam int NUM_CH = 3;

endpackage

// File: rtl/router_fsm_if.sv
// Control-path bundle between the packet source / FIFO status and the
// router FSM; the FSM side is the slave modport.
interface router_fsm_if;

    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  busy, detect_add, lfd_state, ld_state, laf_state,
        input  full_state, rst_int_reg, write_enb_reg
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output busy, detect_add, lfd_state, ld_state, laf_state,
        output full_state, rst_int_reg, write_enb_reg
    );

endinterface

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences header/payload/
// parity and FIFO-full back-pressure, and emits Moore state strobes.
module router_fsm
    import router_pkg::*;
(
    input logic         clk,
    input logic         rst,
    router_fsm_if.slave bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         addr_q, addr_d;
    logic               hdr_empty;
    logic               sel_empty;
    logic               sel_soft_reset;

    // Empty flag of the channel named by the incoming header.
    always_comb begin
        hdr_empty = 1'b0;
        case (bus.data_in)
            2'd0:    hdr_empty = bus.fifo_empty_0;
            2'd1:    hdr_empty = bus.fifo_empty_1;
            2'd2:    hdr_empty = bus.fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
    end

    // Status of the channel latched for the packet in flight.
    always_comb begin
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
        case (addr_q)
            2'd0: begin
                sel_empty      = bus.fifo_empty_0;
                sel_soft_reset = bus.soft_reset_0;
            end
            2'd1: begin
                sel_empty      = bus.fifo_empty_1;
                sel_soft_reset = bus.soft_reset_1;
            end
            2'd2: begin
                sel_empty      = bus.fifo_empty_2;
                sel_soft_reset = bus.soft_reset_2;
            end
            default: begin
                sel_empty      = 1'b0;
                sel_soft_reset = 1'b0;
            end
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (state_q == DECODE_ADDRESS && bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
            addr_d = bus.data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != DECODE_ADDRESS && sel_soft_reset) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
                        state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!bus.pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                FIFO_FULL_STATE: begin
                    if (!bus.fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (bus.low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty) begin
                        state_d = LOAD_FIRST_DATA;
                    end
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.busy          = !(state_q == DECODE_ADDRESS || state_q == LOAD_DATA);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                             || (state_q == LOAD_AFTER_FULL);

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm: expected strobe vectors are queued
// per cycle and a monitor compares them just after each rising edge.
module tb_router_fsm;
    import router_pkg::*;

    logic clk;
    logic rst;
    router_fsm_if bus ();

    router_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // {busy, detect_add, lfd, ld, laf, full, rst_int, wen} per state, by hand.
    function automatic logic [7:0] exp_of(input logic [2:0] st);
        case (st)
            DECODE_ADDRESS:     return 8'b0100_0000;
            LOAD_FIRST_DATA:    return 8'b1010_0000;
            LOAD_DATA:          return 8'b0001_0001;
            LOAD_PARITY:        return 8'b1000_0001;
            CHECK_PARITY_ERROR: return 8'b1000_0010;
            FIFO_FULL_STATE:    return 8'b1000_0100;
            LOAD_AFTER_FULL:    return 8'b1000_1001;
            default:            return 8'b1000_0000;
        endcase
    endfunction

    function automatic logic [7:0] outs();
        return {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                bus.laf_state, bus.full_state, bus.rst_int_reg, bus.write_enb_reg};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Queue the state expected after the coming edge, then advance one cycle.
    task automatic tick(input string name, input logic [2:0] st);
        exp_t e;
        e.name = name;
        e.exp  = exp_of(st);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, outs(), e.exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        #3;
        check("reset_outputs", outs(), exp_of(DECODE_ADDRESS));
        @(negedge clk);
        rst = 1'b0;
        tick("idle", DECODE_ADDRESS);

        // Normal packet to channel 1, three payload cycles.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        tick("norm_hdr", LOAD_FIRST_DATA);
        bus.data_in = 2'd2;
        tick("norm_ld1", LOAD_DATA);
        tick("norm_ld2", LOAD_DATA);
        tick("norm_ld3", LOAD_DATA);
        bus.pkt_valid = 1'b0;
        tick("norm_lp", LOAD_PARITY);
        tick("norm_cpe", CHECK_PARITY_ERROR);
        tick("norm_da", DECODE_ADDRESS);

        // Address 3 is dropped; latched address stays at 1.
        bus.pkt_valid = 1'b1;
        bus.data_in   = ADDR_INVALID;
        tick("inv_da1", DECODE_ADDRESS);
        tick("inv_da2", DECODE_ADDRESS);
        bus.pkt_valid = 1'b0;
        check("inv_addr_q", {6'd0, dut.addr_q}, 8'd1);

        // FIFO full for four cycles in the middle of the payload.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd0;
        tick("ful_hdr", LOAD_FIRST_DATA);
        tick("ful_ld", LOAD_DATA);
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) tick("ful_ffs", FIFO_FULL_STATE);
        bus.fifo_full = 1'b0;
        tick("ful_laf", LOAD_AFTER_FULL);
        tick("ful_ld_again", LOAD_DATA);
        bus.pkt_valid = 1'b0;
        tick("ful_lp", LOAD_PARITY);
        tick("ful_cpe", CHECK_PARITY_ERROR);
        tick("ful_da", DECODE_ADDRESS);

        // Full on parity: LAF with low_pkt_valid returns through LP.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        tick("par_hdr", LOAD_FIRST_DATA);
        tick("par_ld", LOAD_DATA);
        bus.fifo_full = 1'b1;
        tick("par_ffs", FIFO_FULL_STATE);
        bus.fifo_full     = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.low_pkt_valid = 1'b1;
        tick("par_laf", LOAD_AFTER_FULL);
        tick("par_lp", LOAD_PARITY);
        bus.low_pkt_valid = 1'b0;
        tick("par_cpe", CHECK_PARITY_ERROR);
        tick("par_da", DECODE_ADDRESS);

        // parity_done in LAF wins over low_pkt_valid and goes straight home.
        bus.pkt_valid = 1'b1;
        tick("pd_hdr", LOAD_FIRST_DATA);
        tick("pd_ld", LOAD_DATA);
        bus.fifo_full = 1'b1;
        tick("pd_ffs", FIFO_FULL_STATE);
        bus.fifo_full     = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.low_pkt_valid = 1'b1;
        tick("pd_laf", LOAD_AFTER_FULL);
        bus.parity_done = 1'b1;
        tick("pd_da", DECODE_ADDRESS);
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;

        // CPE with FIFO full goes to FFS.
        bus.pkt_valid = 1'b1;
        tick("cf_hdr", LOAD_FIRST_DATA);
        bus.pkt_valid = 1'b0;
        tick("cf_ld", LOAD_DATA);
        tick("cf_lp", LOAD_PARITY);
        tick("cf_cpe", CHECK_PARITY_ERROR);
        bus.fifo_full = 1'b1;
        tick("cf_ffs", FIFO_FULL_STATE);
        bus.fifo_full   = 1'b0;
        bus.parity_done = 1'b1;
        tick("cf_laf", LOAD_AFTER_FULL);
        tick("cf_da", DECODE_ADDRESS);
        bus.parity_done = 1'b0;

        // Busy channel 2: wait, ignore foreign soft reset, honour own.
        bus.fifo_empty_2 = 1'b0;
        bus.pkt_valid    = 1'b1;
        bus.data_in      = 2'd2;
        tick("wte_enter", WAIT_TILL_EMPTY);
        bus.pkt_valid = 1'b0;
        tick("wte_hold", WAIT_TILL_EMPTY);
        bus.soft_reset_0 = 1'b1;
        tick("wte_sr0", WAIT_TILL_EMPTY);
        bus.soft_reset_0 = 1'b0;
        bus.soft_reset_2 = 1'b1;
        tick("wte_sr2", DECODE_ADDRESS);
        bus.soft_reset_2 = 1'b0;

        // Wait then drain: empty flag releases WTE into LFD.
        bus.pkt_valid = 1'b1;
        tick("wte2_enter", WAIT_TILL_EMPTY);
        bus.pkt_valid    = 1'b0;
        bus.fifo_empty_2 = 1'b1;
        tick("wte2_lfd", LOAD_FIRST_DATA);
        bus.soft_reset_2 = 1'b1;
        tick("sr_in_ld", DECODE_ADDRESS);
        bus.soft_reset_2 = 1'b0;

        // Asynchronous reset in the middle of LOAD_DATA.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        tick("rst_hdr", LOAD_FIRST_DATA);
        tick("rst_ld", LOAD_DATA);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", outs(), exp_of(DECODE_ADDRESS));
        check("async_rst_addr_q", {6'd0, dut.addr_q}, 8'd0);
        @(negedge clk);
        tick("rst_hold", DECODE_ADDRESS);
        rst           = 1'b0;
        bus.pkt_valid = 1'b0;
        tick("rst_release", DECODE_ADDRESS);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
